// File: rtl/idp_pkg.sv
// Shared definitions for the integer-datapath sequencer: op codes, ALU function
// selects, Y-mux selects and the sequencer state encoding.
package idp_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_MULT = 4'd5,
        OP_DIV  = 4'd6,
        OP_MFHI = 4'd7,
        OP_MFLO = 4'd8
    } op_e;

    localparam logic [4:0] FS_ADD = 5'h02;
    localparam logic [4:0] FS_SUB = 5'h03;
    localparam logic [4:0] FS_AND = 5'h08;
    localparam logic [4:0] FS_OR  = 5'h09;
    localparam logic [4:0] FS_MUL = 5'h1E;
    localparam logic [4:0] FS_DIV = 5'h1F;

    localparam logic [2:0] Y_PC  = 3'd0;
    localparam logic [2:0] Y_DY  = 3'd1;
    localparam logic [2:0] Y_ALU = 3'd2;
    localparam logic [2:0] Y_LO  = 3'd3;
    localparam logic [2:0] Y_HI  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= 4'd8;
    endfunction

endpackage

// File: rtl/idp_seq_decode.sv
// Pure combinational map from a latched op code to its datapath control class.
module idp_seq_decode
    import idp_pkg::*;
(
    input  logic [3:0] op,
    output logic [4:0] fs,
    output logic       t_sel,
    output logic [2:0] y_sel,
    output logic       wr_en,
    output logic       multi_cycle
);

    always_comb begin
        fs          = 5'd0;
        t_sel       = 1'b0;
        y_sel       = Y_ALU;
        wr_en       = 1'b0;
        multi_cycle = 1'b0;
        case (op)
            OP_ADD:  begin fs = FS_ADD; wr_en = 1'b1; end
            OP_SUB:  begin fs = FS_SUB; wr_en = 1'b1; end
            OP_AND:  begin fs = FS_AND; wr_en = 1'b1; end
            OP_OR:   begin fs = FS_OR;  wr_en = 1'b1; end
            OP_ADDI: begin fs = FS_ADD; wr_en = 1'b1; t_sel = 1'b1; end
            OP_MULT: begin fs = FS_MUL; multi_cycle = 1'b1; end
            OP_DIV:  begin fs = FS_DIV; multi_cycle = 1'b1; end
            OP_MFHI: begin y_sel = Y_HI; wr_en = 1'b1; end
            OP_MFLO: begin y_sel = Y_LO; wr_en = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/idp_sequencer.sv
// Multi-cycle control sequencer: accepts one decoded op over valid/ready and
// drives register-file, ALU, HI/LO and Y-mux controls until it retires.
module idp_sequencer
    import idp_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [31:0] req_imm,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [4:0]  S_Addr,
    output logic [4:0]  T_Addr,
    output logic [4:0]  D_Addr,
    output logic        D_En,
    output logic [4:0]  FS,
    output logic        T_Sel,
    output logic [31:0] DT,
    output logic        HILO_ld,
    output logic [2:0]  Y_Sel
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_e      state, state_nx;
    logic [3:0]  op_q;
    logic [4:0]  rd_q, rs_q, rt_q;
    logic [31:0] imm_q;
    logic [3:0]  cnt_q;
    logic        err_q;

    logic [4:0]  dec_fs;
    logic        dec_t_sel;
    logic [2:0]  dec_y_sel;
    logic        dec_wr_en;
    logic        dec_multi;

    idp_seq_decode u_decode (
        .op          (op_q),
        .fs          (dec_fs),
        .t_sel       (dec_t_sel),
        .y_sel       (dec_y_sel),
        .wr_en       (dec_wr_en),
        .multi_cycle (dec_multi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            op_q  <= 4'd0;
            rd_q  <= 5'd0;
            rs_q  <= 5'd0;
            rt_q  <= 5'd0;
            imm_q <= 32'd0;
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req_valid) begin
                op_q  <= req_op;
                rd_q  <= req_rd;
                rs_q  <= req_rs;
                rt_q  <= req_rt;
                imm_q <= req_imm;
                err_q <= !op_is_legal(req_op);
                if (req_op == OP_MULT)
                    cnt_q <= MUL_CNT;
                else if (req_op == OP_DIV)
                    cnt_q <= DIV_CNT;
                else
                    cnt_q <= 4'd0;
            end else if (state == ST_EXEC && dec_multi && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Datapath controls depend only on state and latched fields, never on req_*.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        S_Addr    = 5'd0;
        T_Addr    = 5'd0;
        D_Addr    = 5'd0;
        D_En      = 1'b0;
        FS        = 5'd0;
        T_Sel     = 1'b0;
        DT        = 32'd0;
        HILO_ld   = 1'b0;
        Y_Sel     = Y_ALU;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    state_nx = op_is_legal(req_op) ? ST_EXEC : ST_DONE;
            end
            ST_EXEC: begin
                S_Addr = rs_q;
                T_Addr = rt_q;
                FS     = dec_fs;
                if (dec_multi) begin
                    if (cnt_q == 4'd0) begin
                        HILO_ld  = 1'b1;
                        state_nx = ST_DONE;
                    end
                end else begin
                    D_Addr   = rd_q;
                    D_En     = dec_wr_en && (rd_q != 5'd0);
                    T_Sel    = dec_t_sel;
                    DT       = dec_t_sel ? imm_q : 32'd0;
                    Y_Sel    = dec_y_sel;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: doc/idp_sequencer.md
Name: idp_sequencer

Overview:
- Multi-cycle control sequencer for the integer datapath (register file + ALU + HI/LO + T/Y muxes).
- Accepts one decoded operation at a time from an upstream requester over a valid/ready handshake.
- Drives the datapath control lines over one or more cycles, including multi-cycle MULT/DIV holds and the HI/LO capture.
- Signals completion with a one-cycle done pulse.

Parameters:
- MUL_LAT, 1, cycles the ALU multiply result must be held stable before HILO_ld (legal range 1..15).
- DIV_LAT, 4, cycles the ALU divide result must be held stable before HILO_ld (legal range 1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream has an operation.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  4  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 MULT, 6 DIV, 7 MFHI, 8 MFLO; 9..15 illegal.
- req_rd  in  5  destination register.
- req_rs  in  5  source S register.
- req_rt  in  5  source T register.
- req_imm  in  32  immediate, used by ADDI only.
- done  out  1  one-cycle pulse when an operation retires.
- err  out  1  one-cycle pulse, coincident with done, for an illegal op.
- busy  out  1  high whenever state is not IDLE.
- S_Addr  out  5  to datapath.
- T_Addr  out  5  to datapath.
- D_Addr  out  5  to datapath.
- D_En  out  1  to datapath.
- FS  out  5  to datapath.
- T_Sel  out  1  to datapath.
- DT  out  32  to datapath.
- HILO_ld  out  1  to datapath.
- Y_Sel  out  3  to datapath.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; internal latches and counter clear.
  - Outputs: req_ready=1 after reset release; done, err, busy, D_En, HILO_ld, T_Sel = 0; all addresses, FS and DT = 0; Y_Sel = 2 (ALU low).
- Reset asserted mid-operation aborts it: no D_En, no HILO_ld and no done are issued afterwards.
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op/rd/rs/rt/imm.
  - Load cnt = MUL_LAT-1 (op 5), DIV_LAT-1 (op 6), else 0.
  - Go to EXEC if the op is legal; go to DONE with an err flag if it is illegal.
- EXEC: drive S_Addr=rs and T_Addr=rt continuously.
  - ADD/SUB/AND/OR: FS from package constant, T_Sel=0, Y_Sel=2, D_Addr=rd, D_En=1 for one cycle; then DONE.
  - ADDI: same as ADD, but T_Sel=1 and DT=imm.
  - MULT/DIV: FS held for the whole hold period.
    - While cnt!=0: decrement, D_En=0, HILO_ld=0.
    - When cnt==0: HILO_ld=1 for exactly one cycle; then DONE.
    - D_En is never asserted for MULT/DIV.
  - MFHI: Y_Sel=4, D_Addr=rd, D_En=1, one cycle; then DONE.
  - MFLO: Y_Sel=3, D_Addr=rd, D_En=1, one cycle; then DONE.
- DONE: done=1 (err=1 if the op was flagged illegal); next state IDLE.
- Register 0 writes: rd==0 suppresses D_En; the op still retires with done.
- Latency, counted from the accept edge:
  - Single-cycle ops: write in EXEC at +1, done at +2.
  - MULT/DIV: HILO_ld at +LAT, done at +LAT+1.
  - Illegal op: done/err at +1.
- Handshake:
  - Requests while busy are not accepted (req_ready=0).
  - The requester must hold its fields until accepted; fields are sampled only at the accept edge.
  - Back-to-back throughput is one op per (latency+1) cycles; IDLE always spends one cycle before the next accept.
- Outputs not listed for a state take their reset defaults; in particular D_En and HILO_ld are never high outside EXEC.
- Outputs are combinational decodes of registered state and latches; no combinational path from req_* to datapath controls.

Decomposition:
- Shared package idp_pkg holds:
  - op codes;
  - FS constants: FS_ADD=5'h02, FS_SUB=5'h03, FS_AND=5'h08, FS_OR=5'h09, FS_MUL=5'h1E, FS_DIV=5'h1F;
  - Y_Sel constants: Y_PC=0, Y_DY=1, Y_ALU=2, Y_LO=3, Y_HI=4;
  - state encoding.
- One natural sub-module: idp_seq_decode, a pure combinational map from latched op to FS/T_Sel/Y_Sel/write-enable/latency class.

Test Plan:
- Reset, then ADD rd=3 rs=1 rt=2 with R1=5, R2=7 -> D_En=1, D_Addr=3, FS=02 at accept+1; done at +2; R3=12.
- ADDI rd=4 rs=1 imm=32'hFFFF_FFFF with R1=5 -> T_Sel=1, DT=FFFF_FFFF; R4=4; done at +2.
- DIV with DIV_LAT=4, R1=20, R2=3 -> FS=1F held 4 cycles; HILO_ld only at +4; D_En never high; done at +5. Follow with MFLO rd=5 -> R5=6 and MFHI rd=6 -> R6=2.
- req_op=12 -> err=done=1 at +1; no D_En or HILO_ld. Also ADD rd=0 -> D_En stays 0; done at +2.
- req_valid held high with a second op during MULT -> req_ready=0 until IDLE; the second op is accepted exactly one cycle after done.
- reset_n pulled low during a DIV hold (cnt=2) -> immediate IDLE, HILO_ld never pulses, HI/LO unchanged, no done.
